// File: rtl/i2c_master_1_if.sv
// i2c_master_1_if: user-side request/response bundle and SCL/SDA-enable view
// of the single-byte I2C register master.
interface i2c_master_1_if;
  logic       start;
  logic       rw;
  logic [6:0] dev_addr;
  logic [7:0] reg_index;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       busy;
  logic       done;
  logic       ack_error;
  logic       scl;
  logic       sda_enable;

  modport master (
    output start, rw, dev_addr, reg_index, wr_data,
    input  rd_data, busy, done, ack_error, scl, sda_enable
  );

  modport slave (
    input  start, rw, dev_addr, reg_index, wr_data,
    output rd_data, busy, done, ack_error, scl, sda_enable
  );
endinterface

// File: rtl/i2c_master_1.sv
// i2c_master_1: one register write or one repeated-START register read
// per request; push-pull SCL, open-drain SDA, no stretching or arbitration.
module i2c_master_1 #(
  parameter int QTR = 250
) (
  input  logic          clk,
  input  logic          rst,
  i2c_master_1_if.slave bus,
  inout  wire           sda
);
  localparam int QW = (QTR > 1) ? $clog2(QTR) : 1;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK_A,
    INDEX, ACK_I, WDATA, ACK_W,
    RSTART, ADDR_R, ACK_R, RDATA,
    MNACK, ERR, STOP, DONE
  } state_t;

  state_t        state, state_nx;
  logic [QW-1:0] qcnt;
  logic [1:0]    phase;
  logic [2:0]    bitcnt;
  logic [7:0]    sh;
  logic [7:0]    idx_q;
  logic [7:0]    wdat_q;
  logic [7:0]    rd_q;
  logic [6:0]    addr_q;
  logic          rw_q;
  logic          err_q;
  logic          ackerr_q;

  logic sda_in;
  logic q_last;
  logic slot_end;
  logic sample;
  logic last_bit;
  logic nack;
  logic accept;
  logic run;
  logic mid;
  logic scl_c;
  logic oe;
  logic sdo;

  assign sda_in   = sda;
  assign q_last   = qcnt == QW'(QTR - 1);
  assign slot_end = q_last && phase == 2'd3;
  assign sample   = q_last && phase == 2'd2;
  assign last_bit = slot_end && bitcnt == 3'd7;
  assign nack     = sample && sda_in;
  assign accept   = state == IDLE && bus.start;
  assign run      = state != IDLE && state != DONE;
  assign mid      = phase[0] ^ phase[1];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (bus.start) state_nx = START;
      START:  if (slot_end) state_nx = ADDR;
      ADDR:   if (last_bit) state_nx = ACK_A;
      ACK_A: begin
        if (nack) state_nx = ERR;
        else if (slot_end) state_nx = INDEX;
      end
      INDEX:  if (last_bit) state_nx = ACK_I;
      ACK_I: begin
        if (nack) state_nx = ERR;
        else if (slot_end) state_nx = rw_q ? RSTART : WDATA;
      end
      WDATA:  if (last_bit) state_nx = ACK_W;
      ACK_W: begin
        if (nack) state_nx = ERR;
        else if (slot_end) state_nx = STOP;
      end
      RSTART: if (slot_end) state_nx = ADDR_R;
      ADDR_R: if (last_bit) state_nx = ACK_R;
      ACK_R: begin
        if (nack) state_nx = ERR;
        else if (slot_end) state_nx = RDATA;
      end
      RDATA:  if (last_bit) state_nx = MNACK;
      MNACK:  if (slot_end) state_nx = STOP;
      ERR:    if (slot_end) state_nx = STOP;
      STOP:   if (slot_end) state_nx = DONE;
      DONE:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ERR only covers the tail quarter of the failed ACK slot
  always_comb begin
    scl_c = 1'b1;
    oe    = 1'b0;
    sdo   = 1'b1;
    unique case (state)
      START, RSTART: begin
        scl_c = phase != 2'd3;
        oe    = 1'b1;
        sdo   = phase == 2'd0;
      end
      ADDR, INDEX, WDATA, ADDR_R: begin
        scl_c = mid;
        oe    = 1'b1;
        sdo   = sh[7];
      end
      ACK_A, ACK_I, ACK_W, ACK_R, RDATA, ERR: begin
        scl_c = mid;
      end
      MNACK: begin
        scl_c = mid;
        oe    = 1'b1;
      end
      STOP: begin
        scl_c = phase != 2'd0;
        oe    = 1'b1;
        sdo   = phase == 2'd3;
      end
      default: begin
        scl_c = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      qcnt     <= '0;
      phase    <= '0;
      bitcnt   <= '0;
      sh       <= '0;
      idx_q    <= '0;
      wdat_q   <= '0;
      addr_q   <= '0;
      rw_q     <= 1'b0;
      err_q    <= 1'b0;
      ackerr_q <= 1'b0;
      rd_q     <= '0;
    end else begin
      state <= state_nx;
      if (!run) begin
        qcnt  <= '0;
        phase <= '0;
      end else if (q_last) begin
        qcnt  <= '0;
        phase <= phase + 2'd1;
      end else begin
        qcnt <= qcnt + 1'b1;
      end
      if (accept) begin
        rw_q     <= bus.rw;
        addr_q   <= bus.dev_addr;
        idx_q    <= bus.reg_index;
        wdat_q   <= bus.wr_data;
        sh       <= {bus.dev_addr, 1'b0};
        bitcnt   <= '0;
        err_q    <= 1'b0;
        ackerr_q <= 1'b0;
      end
      if (slot_end) begin
        case (state)
          ADDR, INDEX, WDATA, ADDR_R: begin
            sh     <= {sh[6:0], 1'b0};
            bitcnt <= bitcnt + 3'd1;
          end
          RDATA: bitcnt <= bitcnt + 3'd1;
          ACK_A: sh <= idx_q;
          ACK_I: sh <= rw_q ? {addr_q, 1'b1} : wdat_q;
          MNACK: rd_q <= sh;
          STOP:  ackerr_q <= err_q;
          default: ;
        endcase
      end
      if (sample && state == RDATA) sh <= {sh[6:0], sda_in};
      if (state == ERR) err_q <= 1'b1;
    end
  end

  assign sda            = (oe && !sdo) ? 1'b0 : 1'bz;
  assign bus.scl        = scl_c;
  assign bus.sda_enable = oe;
  assign bus.busy       = run;
  assign bus.done       = state == DONE;
  assign bus.rd_data    = rd_q;
  assign bus.ack_error  = ackerr_q;
endmodule

// File: tb/tb_i2c_master_1.sv
// tb_i2c_master_1: directed bench with an ESC-like I2C slave at 0x50,
// bus byte trace, latency and SCL duty checks at QTR=4.
`timescale 1ns/1ps
module tb_i2c_master_1;
  localparam int QTR = 4;
  localparam logic [6:0] SLV = 7'h50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wire sda;
  pullup (sda);
  logic slv_low = 1'b0;
  assign sda = slv_low ? 1'b0 : 1'bz;

  i2c_master_1_if bus();

  i2c_master_1 #(.QTR(QTR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .sda (sda)
  );

  int npass = 0;
  int ntot  = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // slave model: decodes START/STOP/bits from the wires
  logic [7:0] regs [256];
  int         trace[$];
  int         bitn = 0;
  int         bytn = 0;
  logic [7:0] sh_s = 8'h00;
  logic [7:0] idx_s = 8'h00;
  logic       rd_mode = 1'b0;
  logic       addr_ok = 1'b0;
  logic       mnack = 1'b0;
  logic       p_scl = 1'b1;
  logic       p_sda = 1'b1;

  always @(bus.scl or sda or rst) begin
    if (rst) begin
      slv_low = 1'b0;
      bitn = 0;
      bytn = 0;
      rd_mode = 1'b0;
      regs[8'h42] = 8'h9A;
    end else if (bus.scl && p_scl && p_sda && !sda) begin
      trace.push_back(-1);
      bitn = 0;
      bytn = 0;
      rd_mode = 1'b0;
      slv_low = 1'b0;
    end else if (bus.scl && p_scl && !p_sda && sda) begin
      trace.push_back(-2);
      bitn = 0;
      bytn = 0;
      rd_mode = 1'b0;
    end else if (bus.scl && !p_scl) begin
      if (bitn < 8) sh_s = {sh_s[6:0], sda};
      else mnack = sda;
      bitn++;
    end else if (!bus.scl && p_scl) begin
      if (bitn == 8) begin
        trace.push_back(int'(sh_s));
        if (bytn == 0) begin
          addr_ok = sh_s[7:1] == SLV;
          rd_mode = sh_s[0] & addr_ok;
          slv_low = addr_ok;
        end else if (rd_mode) begin
          slv_low = 1'b0;
        end else begin
          slv_low = addr_ok;
          if (addr_ok && bytn == 1) idx_s = sh_s;
          if (addr_ok && bytn == 2) regs[idx_s] = sh_s;
        end
      end else if (bitn == 9) begin
        slv_low = (rd_mode && bytn == 0) ? ~regs[idx_s][7] : 1'b0;
        bitn = 0;
        bytn++;
      end else if (bitn >= 1 && bitn <= 7 && rd_mode && bytn > 0) begin
        slv_low = ~regs[idx_s][7 - bitn];
      end
    end
    p_scl = bus.scl;
    p_sda = sda;
  end

  // SCL high/low width statistics over a window
  logic meas = 1'b0;
  logic p_meas = 1'b0;
  logic p_scl2 = 1'b1;
  logic seen_pos = 1'b0;
  logic seen_neg = 1'b0;
  int t_pos = 0, t_neg = 0, w = 0;
  int hmin = 0, hmax = 0, lmin = 0, lmax = 0, hcnt = 0, lcnt = 0;

  always @(bus.scl or meas) begin
    if (meas && !p_meas) begin
      hcnt = 0; lcnt = 0;
      hmin = 999; hmax = 0;
      lmin = 999; lmax = 0;
      seen_pos = 1'b0;
      seen_neg = 1'b0;
    end else if (meas && bus.scl !== p_scl2) begin
      if (bus.scl) begin
        if (seen_neg) begin
          w = cyc - t_neg;
          lcnt++;
          if (w < lmin) lmin = w;
          if (w > lmax) lmax = w;
        end
        seen_pos = 1'b1;
        t_pos = cyc;
      end else begin
        if (seen_pos) begin
          w = cyc - t_pos;
          hcnt++;
          if (w < hmin) hmin = w;
          if (w > hmax) hmax = w;
        end
        seen_neg = 1'b1;
        t_neg = cyc;
      end
    end
    p_meas = meas;
    p_scl2 = bus.scl;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  int exp_q[$];
  int mark = 0;

  task automatic chk_trace(input string tag);
    chk({tag, "_len"}, trace.size() - mark, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (mark + i < trace.size()) chk(tag, trace[mark + i], exp_q[i]);
  endtask

  task automatic launch(input logic r, input logic [6:0] a,
                        input logic [7:0] ix, input logic [7:0] wd,
                        output int c0);
    @(negedge clk);
    bus.rw = r;
    bus.dev_addr = a;
    bus.reg_index = ix;
    bus.wr_data = wd;
    bus.start = 1'b1;
    mark = trace.size();
    @(posedge clk);
    #1;
    c0 = cyc;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int lat);
    int n = 0;
    while (bus.done !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = cyc - c0 + 1;
  endtask

  int c0 = 0;
  int lat = 0;

  initial begin
    bus.start = 1'b0;
    bus.rw = 1'b0;
    bus.dev_addr = 7'h00;
    bus.reg_index = 8'h00;
    bus.wr_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_scl", bus.scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_oe", bus.sda_enable, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_ackerr", bus.ack_error, 0);
    chk("rst_rdata", bus.rd_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    // register write with bit-timing window
    meas = 1'b1;
    launch(1'b0, 7'h50, 8'h41, 8'h3C, c0);
    chk("wr_busy", bus.busy, 1);
    wait_done(c0, lat);
    meas = 1'b0;
    chk("wr_lat", lat, 465);
    chk("wr_ackerr", bus.ack_error, 0);
    chk("wr_reg41", regs[8'h41], 8'h3C);
    exp_q = '{-1, 'hA0, 'h41, 'h3C, -2};
    chk_trace("wr_trace");
    chk("scl_hmin", hmin, 8);
    chk("scl_hmax", hmax, 8);
    chk("scl_hcnt", hcnt, 27);
    chk("scl_lmin", lmin, 8);
    chk("scl_lmax", lmax, 8);
    chk("scl_lcnt", lcnt, 28);
    @(posedge clk);
    #1;
    chk("done_pulse", bus.done, 0);
    repeat (3) @(posedge clk);

    // register read with repeated START
    launch(1'b1, 7'h50, 8'h42, 8'h00, c0);
    wait_done(c0, lat);
    chk("rd_lat", lat, 625);
    chk("rd_data", bus.rd_data, 8'h9A);
    chk("rd_ackerr", bus.ack_error, 0);
    chk("rd_mnack", mnack, 1);
    exp_q = '{-1, 'hA0, 'h42, -1, 'hA1, 'h9A, -2};
    chk_trace("rd_trace");
    repeat (3) @(posedge clk);

    // no device at 0x51
    launch(1'b0, 7'h51, 8'h10, 8'h55, c0);
    wait_done(c0, lat);
    chk("nack_lat", lat, 177);
    chk("nack_ackerr", bus.ack_error, 1);
    chk("nack_rdata", bus.rd_data, 8'h9A);
    exp_q = '{-1, 'hA2, -2};
    chk_trace("nack_trace");
    repeat (3) @(posedge clk);

    // stray start mid-transfer, then start held through DONE
    launch(1'b0, 7'h50, 8'h43, 8'h5A, c0);
    chk("clr_ackerr", bus.ack_error, 0);
    repeat (100) @(posedge clk);
    @(negedge clk);
    bus.rw = 1'b1;
    bus.dev_addr = 7'h51;
    bus.reg_index = 8'h77;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < c0 + 400) @(posedge clk);
    @(negedge clk);
    bus.rw = 1'b0;
    bus.dev_addr = 7'h50;
    bus.reg_index = 8'h44;
    bus.wr_data = 8'hA5;
    bus.start = 1'b1;
    wait_done(c0, lat);
    chk("mid_lat", lat, 465);
    chk("mid_reg43", regs[8'h43], 8'h5A);
    exp_q = '{-1, 'hA0, 'h43, 'h5A, -2};
    chk_trace("mid_trace");
    mark = trace.size();
    @(posedge clk);
    #1;
    chk("held_idle", bus.busy, 0);
    @(posedge clk);
    #1;
    chk("held_busy", bus.busy, 1);
    c0 = cyc;
    bus.start = 1'b0;
    wait_done(c0, lat);
    chk("held_lat", lat, 465);
    chk("held_reg44", regs[8'h44], 8'hA5);
    exp_q = '{-1, 'hA0, 'h44, 'hA5, -2};
    chk_trace("held_trace");
    repeat (3) @(posedge clk);

    // reset in the middle of RDATA bit 3
    launch(1'b1, 7'h50, 8'h42, 8'h00, c0);
    while (cyc < c0 + 32 * 16 + 6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_scl", bus.scl, 1);
    chk("mrst_oe", bus.sda_enable, 0);
    chk("mrst_sda", sda, 1);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_rdata", bus.rd_data, 8'h00);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    launch(1'b0, 7'h50, 8'h45, 8'hC3, c0);
    wait_done(c0, lat);
    chk("post_lat", lat, 465);
    chk("post_reg45", regs[8'h45], 8'hC3);
    chk("post_ackerr", bus.ack_error, 0);
    exp_q = '{-1, 'hA0, 'h45, 'hC3, -2};
    chk_trace("post_trace");

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/i2c_master_1.md
Name: i2c_master_1

Overview:
- Single-byte I2C master: the initiator that writes and reads the ESC register map (PID gains, period reference, override, autotune reset) through the ESC's I2C slave.
- Sits on the host/controller board, or on a test fabric driving JB1/JB2.
- A user-side request/done handshake launches one register write or one register read (repeated-START form).
- No clock stretching, no multi-master arbitration.

Parameters:
QTR, 250, clk cycles per quarter SCL bit period (one bit slot = 4*QTR cycles); legal range ≥2.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
start  input  1  request strobe, sampled in IDLE only
rw  input  1  0 = register write, 1 = register read; latched with start
dev_addr  input  7  7-bit slave address; latched with start
reg_index  input  8  register index byte; latched with start
wr_data  input  8  write payload; latched with start
rd_data  output  8  byte returned by the last successful read
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse at transaction end
ack_error  output  1  set at done if any slave ACK was missing; cleared at next accepted start
scl  output  1  SCL, push-pull
sda  inout  1  SDA, open-drain: 0 driven, 1 released (z)
sda_enable  output  1  high while the master owns SDA

Behaviour:
Reset values (rst=1 at a clk edge, including mid-transaction; transaction abandoned, no STOP issued):
- scl=1, sda released, sda_enable=0, busy=0, done=0, ack_error=0, rd_data=8'h00.
- FSM returns to IDLE; quarter counter and bit counter cleared.

Quarter counter and bit slots:
- The quarter counter runs 0..QTR-1 and advances the phase q0..q3.
- Data slot: q0 scl=0, SDA updated at q0 start; q1,q2 scl=1; q3 scl=0.
- SDA is sampled on the last cycle of q2.
- START slot: q0 SDA released and scl=1; q1 SDA driven 0; q2 scl=1; q3 scl=0.
- STOP slot: q0 scl=0, SDA driven 0; q1,q2 scl=1; q3 scl=1 and SDA released.

FSM:
- IDLE: scl=1, SDA released.
  - On start=1, latch the inputs, clear ack_error, set busy, go to START.
  - start while busy is ignored.
- START -> ADDR.
- ADDR: 8 slots, {dev_addr,1'b0}, MSB first -> ACK_A.
- ACK_A: SDA released, sda_enable=0, sample. 1 -> ERR; 0 -> INDEX.
- INDEX: 8 slots of reg_index -> ACK_I. 1 -> ERR; 0 -> WDATA if rw=0, RSTART if rw=1.
- Write path:
  - WDATA: 8 slots of wr_data -> ACK_W.
  - ACK_W: 1 -> ERR; 0 -> STOP.
- Read path:
  - RSTART: a START slot -> ADDR_R.
  - ADDR_R: {dev_addr,1'b1} -> ACK_R.
  - ACK_R: 1 -> ERR; 0 -> RDATA.
  - RDATA: 8 slots, SDA released, bits shifted in MSB first -> MNACK.
  - MNACK: master releases SDA (NACK), sda_enable=1 -> STOP.
  - rd_data is updated from the shift register when MNACK completes.
- ERR: set the ack_error flag, then STOP.
- STOP -> DONE.
- DONE: one cycle, done=1, busy=0 -> IDLE.
- A start held high through DONE is accepted in IDLE on the next cycle.

sda_enable:
- 1 during START, RSTART, STOP, address/index/data bit slots, and MNACK.
- 0 during ACK slots, RDATA and IDLE.

Latency:
- Accepted start to done pulse: write = 29 slots, read = 39 slots; each slot = 4*QTR cycles, plus 1 cycle for DONE.
- NACK at ACK_A: 11 slots + 1 cycle.
- rd_data and ack_error are stable from the done pulse until the next accepted start.
- On error, rd_data keeps its previous value.

Test Plan:
- Write, QTR=4, rw=0, dev_addr=7'h50, reg_index=8'h41, wr_data=8'h3C, slave model ACKs -> SDA bytes A0, 41, 3C with START/STOP framing; done exactly 465 cycles after start; ack_error=0; ESC model reg 0x41=0x3C.
- Read, QTR=4, rw=1, reg_index=8'h42, slave returns 8'h9A -> bytes A0, 42, Sr, A1; master NACK on the 9th slot; done at 625 cycles; rd_data=8'h9A.
- Address NACK, no slave at 7'h51 -> STOP after ACK_A; done at 177 cycles; ack_error=1; rd_data unchanged.
- start pulsed mid-transaction, then start held through DONE -> mid-transaction pulse ignored (bus trace identical to a single transfer); a second transaction begins the cycle after DONE.
- rst asserted during RDATA bit 3 -> next cycle scl=1, SDA z, busy=0, done=0, rd_data=0; a subsequent write completes normally.
- Bit timing check at QTR=4 -> SDA never changes while scl=1 except at START/STOP; scl high time = 8 cycles, low time = 8 cycles.
